// File: rtl/tlv493_i2c_slave.sv
`timescale 1ns/1ps
// TLV493D emulation responder: serves the 10-byte read map from fabric-supplied
// samples and captures the 4-byte configuration write on a shared I2C bus.
module tlv493_i2c_slave #(
  parameter logic [6:0]  I2C_ADDR      = 7'h5E,
  parameter logic [23:0] FACTORY_BYTES = 24'h000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [11:0] mag_x,
  input  logic [11:0] mag_y,
  input  logic [11:0] mag_z,
  input  logic [11:0] temp,
  input  logic        sample_valid,
  output logic [31:0] config_out,
  output logic        config_written,
  output logic        config_parity_ok,
  output logic        busy,
  output logic [1:0]  frm
);

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PTR_W    = 4;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned NUM_RD   = 10;
  localparam int unsigned NUM_WR   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_IGNORE
  } state_t;

  state_t state, state_n;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, bus_start, bus_stop;

  logic               sda_oe, oe_n;
  logic [CNT_W-1:0]   cnt;
  logic [BYTE_W-1:0]  rx, tx, rd_data;
  logic               nack;
  logic [PTR_W-1:0]   ptr;
  logic [IDX_W-1:0]   widx;
  logic [1:0]         stage_sel;
  logic [NUM_WR-1:0][BYTE_W-1:0] staging;

  logic [SAMPLE_W-1:0] live_x, live_y, live_z, live_t;
  logic [SAMPLE_W-1:0] snap_x, snap_y, snap_z, snap_t;
  logic [1:0]          snap_frm;

  logic cnt_clr, cnt_inc, rx_shift, tx_load, tx_shift, snap_take;
  logic ptr_inc, ack_sample, stage_wr, widx_clr, widx_inc, bus_end, busy_set;

  // Open-drain pad: only ever pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one history flop; idle bus level is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign bus_start = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign bus_stop  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign stage_sel = 2'(NUM_WR - 1) - widx[1:0];

  // Read map, always served from the snapshot so a read is never torn.
  always_comb begin
    rd_data = '0;
    case (ptr)
      4'd0:    rd_data = snap_x[11:4];
      4'd1:    rd_data = snap_y[11:4];
      4'd2:    rd_data = snap_z[11:4];
      4'd3:    rd_data = {snap_t[11:8], snap_frm, 2'b00};
      4'd4:    rd_data = {snap_x[3:0], snap_y[3:0]};
      4'd5:    rd_data = {4'b0001, snap_z[3:0]};
      4'd6:    rd_data = snap_t[7:0];
      4'd7:    rd_data = FACTORY_BYTES[23:16];
      4'd8:    rd_data = FACTORY_BYTES[15:8];
      4'd9:    rd_data = FACTORY_BYTES[7:0];
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Bus sequencing: bits sampled on SCL rise, SDA updated on SCL fall.
  always_comb begin
    state_n    = state;
    oe_n       = sda_oe;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    rx_shift   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    snap_take  = 1'b0;
    ptr_inc    = 1'b0;
    ack_sample = 1'b0;
    stage_wr   = 1'b0;
    widx_clr   = 1'b0;
    widx_inc   = 1'b0;
    bus_end    = 1'b0;
    busy_set   = 1'b0;
    if (bus_start || bus_stop) begin
      bus_end = 1'b1;
      oe_n    = 1'b0;
      cnt_clr = 1'b1;
      state_n = bus_start ? S_ADDR : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            rx_shift = 1'b1;
            cnt_inc  = 1'b1;
          end else if (scl_fall && cnt == CNT_W'(BYTE_W)) begin
            cnt_clr = 1'b1;
            if (rx[7:1] == I2C_ADDR) begin
              state_n  = S_ADDR_ACK;
              oe_n     = 1'b1;
              busy_set = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise && rx[0]) begin
            snap_take = 1'b1;
          end else if (scl_fall) begin
            if (rx[0]) begin
              tx_load = 1'b1;
              oe_n    = ~rd_data[BYTE_W-1];
              state_n = S_RD_BYTE;
            end else begin
              widx_clr = 1'b1;
              oe_n     = 1'b0;
              state_n  = S_WR_BYTE;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (cnt == CNT_W'(BYTE_W - 1)) begin
              cnt_clr = 1'b1;
              oe_n    = 1'b0;
              state_n = S_RD_ACK;
            end else begin
              cnt_inc  = 1'b1;
              tx_shift = 1'b1;
              oe_n     = ~tx[BYTE_W-2];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            ack_sample = 1'b1;
            ptr_inc    = ~sda_s2;
          end else if (scl_fall) begin
            if (nack) begin
              state_n = S_IGNORE;
            end else begin
              tx_load = 1'b1;
              oe_n    = ~rd_data[BYTE_W-1];
              state_n = S_RD_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            rx_shift = 1'b1;
            cnt_inc  = 1'b1;
          end else if (scl_fall && cnt == CNT_W'(BYTE_W)) begin
            cnt_clr = 1'b1;
            if (widx < IDX_W'(NUM_WR)) begin
              stage_wr = 1'b1;
              oe_n     = 1'b1;
              state_n  = S_WR_ACK;
            end else begin
              oe_n    = 1'b0;
              state_n = S_IGNORE;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            oe_n     = 1'b0;
            widx_inc = 1'b1;
            state_n  = S_WR_BYTE;
          end
        end
        S_IGNORE: ;
      endcase
    end
  end

  // Shift, pointer, staging and commit datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sda_oe           <= 1'b0;
      cnt              <= '0;
      rx               <= '0;
      tx               <= '0;
      nack             <= 1'b0;
      ptr              <= '0;
      widx             <= '0;
      staging          <= '0;
      busy             <= 1'b0;
      config_out       <= '0;
      config_written   <= 1'b0;
      config_parity_ok <= 1'b0;
    end else begin
      sda_oe         <= oe_n;
      config_written <= 1'b0;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (rx_shift) rx <= {rx[BYTE_W-2:0], sda_s2};
      if (tx_load)       tx <= rd_data;
      else if (tx_shift) tx <= {tx[BYTE_W-2:0], 1'b0};
      if (ack_sample) nack <= sda_s2;
      if (snap_take)    ptr <= '0;
      else if (ptr_inc) ptr <= (ptr == PTR_W'(NUM_RD - 1)) ? '0 : ptr + PTR_W'(1);
      if (stage_wr) staging[stage_sel] <= rx;
      if (bus_end)       widx <= '0;
      else if (widx_clr) widx <= '0;
      else if (widx_inc) widx <= widx + IDX_W'(1);
      if (bus_end && widx == IDX_W'(NUM_WR)) begin
        config_out       <= staging;
        config_parity_ok <= ^staging;
        config_written   <= 1'b1;
      end
      if (bus_end)       busy <= 1'b0;
      else if (busy_set) busy <= 1'b1;
    end
  end

  // Live samples and frame counter; snapshot sees pre-load values on a tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_x   <= '0;
      live_y   <= '0;
      live_z   <= '0;
      live_t   <= '0;
      frm      <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
      snap_z   <= '0;
      snap_t   <= '0;
      snap_frm <= '0;
    end else begin
      if (sample_valid) begin
        live_x <= mag_x;
        live_y <= mag_y;
        live_z <= mag_z;
        live_t <= temp;
        frm    <= frm + 2'(1);
      end
      if (snap_take) begin
        snap_x   <= live_x;
        snap_y   <= live_y;
        snap_z   <= live_z;
        snap_t   <= live_t;
        snap_frm <= frm;
      end
    end
  end

endmodule

// File: tb/tb_tlv493_i2c_slave.sv
`timescale 1ns/1ps
// Directed bench for tlv493_i2c_slave: bit-banged I2C master with
// hand-computed read maps and configuration writes.
module tb_tlv493_i2c_slave;

  localparam time Q = 150;

  logic        clock = 1'b0;
  logic        reset;
  logic        scl;
  logic        m_oe;
  wire         sda;
  logic [11:0] mag_x, mag_y, mag_z, temp;
  logic        sample_valid;
  logic [31:0] config_out;
  logic        config_written;
  logic        config_parity_ok;
  logic        busy;
  logic [1:0]  frm;

  int checks = 0;
  int errors = 0;
  int cw_cnt = 0;

  logic [7:0] rbuf [16];
  logic [7:0] wbuf [5];
  logic [7:0] exp_old [12] = '{8'hAB, 8'h12, 8'hF0, 8'h44, 8'hC3, 8'h1F, 8'h56,
                               8'hA5, 8'hC3, 8'h3C, 8'hAB, 8'h12};
  logic [7:0] exp_new [7]  = '{8'h32, 8'h65, 8'h98, 8'hC8, 8'h14, 8'h17, 8'hBA};

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  tlv493_i2c_slave #(
    .I2C_ADDR      (7'h5E),
    .FACTORY_BYTES (24'hA5C33C)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .scl              (scl),
    .sda              (sda),
    .mag_x            (mag_x),
    .mag_y            (mag_y),
    .mag_z            (mag_z),
    .temp             (temp),
    .sample_valid     (sample_valid),
    .config_out       (config_out),
    .config_written   (config_written),
    .config_parity_ok (config_parity_ok),
    .busy             (busy),
    .frm              (frm)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (config_written === 1'b1) cw_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bit_wr(input logic b);
    m_oe = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic bit_rd(output logic b);
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; m_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_oe = 1'b1; #Q; scl = 1'b1; #Q; m_oe = 1'b0; #(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) bit_wr(d[i]);
    bit_rd(ack_n);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_rd(b);
      d[i] = b;
    end
    bit_wr(nack);
  endtask

  task automatic do_read(input int n, output logic ack_n);
    logic [7:0] d;
    i2c_start;
    wr_byte(8'hBD, ack_n);
    for (int i = 0; i < n; i++) begin
      rd_byte(logic'(i == n - 1), d);
      rbuf[i] = d;
    end
    i2c_stop;
  endtask

  task automatic do_write(input int n, output logic [5:0] acks);
    logic a;
    acks = '0;
    i2c_start;
    wr_byte(8'hBC, a);
    acks[0] = a;
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], a);
      acks[i+1] = a;
    end
    i2c_stop;
  endtask

  task automatic load(input logic [11:0] x, input logic [11:0] y,
                      input logic [11:0] z, input logic [11:0] t);
    @(negedge clock);
    mag_x = x; mag_y = y; mag_z = z; temp = t;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    logic [5:0] acks;
    int         cw0;

    reset = 1'b1; scl = 1'b1; m_oe = 1'b0; sample_valid = 1'b0;
    mag_x = '0; mag_y = '0; mag_z = '0; temp = '0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    check("rst_sda", 32'(sda), 32'd1);
    check("rst_cfg", config_out, 32'h0);
    check("rst_cw", 32'(config_written), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frm", 32'(frm), 32'd0);
    check("rst_par", 32'(config_parity_ok), 32'd0);

    load(12'hABC, 12'h123, 12'hF0F, 12'h456);
    check("frm_load1", 32'(frm), 32'd1);

    // 7-byte read, busy observed after the address ACK
    i2c_start;
    wr_byte(8'hBD, a);
    check("rd7_ack", 32'(a), 32'd0);
    check("rd7_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      rd_byte(logic'(i == 6), d);
      rbuf[i] = d;
    end
    i2c_stop;
    for (int i = 0; i < 7; i++) check($sformatf("rd7_b%0d", i), 32'(rbuf[i]), 32'(exp_old[i]));
    check("rd7_busy_end", 32'(busy), 32'd0);

    // 12-byte read: factory bytes then pointer wrap
    do_read(12, a);
    check("rd12_ack", 32'(a), 32'd0);
    for (int i = 7; i < 12; i++) check($sformatf("rd12_b%0d", i), 32'(rbuf[i]), 32'(exp_old[i]));

    // wrong address ignored, then a correct read works
    i2c_start;
    wr_byte(8'hBF, a);
    check("bad_addr_nack", 32'(a), 32'd1);
    check("bad_addr_busy", 32'(busy), 32'd0);
    i2c_stop;
    do_read(1, a);
    check("after_bad_ack", 32'(a), 32'd0);
    check("after_bad_b0", 32'(rbuf[0]), 32'h0000_00AB);

    // full configuration write
    wbuf[0] = 8'h00; wbuf[1] = 8'h80; wbuf[2] = 8'h00; wbuf[3] = 8'h00;
    cw0 = cw_cnt;
    do_write(4, acks);
    check("wr4_acks", 32'(acks), 32'h0);
    check("wr4_cfg", config_out, 32'h0080_0000);
    check("wr4_pulse", 32'(cw_cnt - cw0), 32'd1);
    check("wr4_par", 32'(config_parity_ok), 32'd1);

    // five bytes: the fifth is NACKed, the first four still commit
    wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'h56; wbuf[3] = 8'h78; wbuf[4] = 8'hFF;
    cw0 = cw_cnt;
    do_write(5, acks);
    check("wr5_acks", 32'(acks), 32'h0000_0020);
    check("wr5_cfg", config_out, 32'h1234_5678);
    check("wr5_pulse", 32'(cw_cnt - cw0), 32'd1);
    check("wr5_par", 32'(config_parity_ok), 32'd1);

    // short write leaves configuration untouched
    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    cw0 = cw_cnt;
    do_write(2, acks);
    check("wr2_acks", 32'(acks), 32'h0);
    check("wr2_cfg", config_out, 32'h1234_5678);
    check("wr2_pulse", 32'(cw_cnt - cw0), 32'd0);

    // sample_valid mid-read: current read keeps old data, next read sees new
    i2c_start;
    wr_byte(8'hBD, a);
    check("tear_ack", 32'(a), 32'd0);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) load(12'h321, 12'h654, 12'h987, 12'hCBA);
      rd_byte(logic'(i == 6), d);
      rbuf[i] = d;
    end
    i2c_stop;
    for (int i = 0; i < 7; i++) check($sformatf("tear_old_b%0d", i), 32'(rbuf[i]), 32'(exp_old[i]));
    check("tear_frm", 32'(frm), 32'd2);
    do_read(7, a);
    for (int i = 0; i < 7; i++) check($sformatf("tear_new_b%0d", i), 32'(rbuf[i]), 32'(exp_new[i]));

    // reset while the slave is pulling SDA low (bit 7 of 0x32 is 0)
    i2c_start;
    wr_byte(8'hBD, a);
    check("rstmid_drive", 32'(sda), 32'd0);
    reset = 1'b1;
    #1;
    check("rstmid_release", 32'(sda), 32'd1);
    #50;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cfg", config_out, 32'h0);
    check("rstmid_frm", 32'(frm), 32'd0);
    i2c_stop;

    // frame counter wraps 3 -> 0
    for (int i = 1; i <= 4; i++) begin
      load(12'h111, 12'h222, 12'h333, 12'h444);
      check($sformatf("frm_seq%0d", i), 32'(frm), 32'(i % 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
